// File: rtl/nt_node_monitor.sv
// nt_node_monitor
// W-channel Nt-node datapath with an optional activity monitor.
//
// Each channel registers b/c/d, forms a gated term with the unregistered
// a_in, and combines the registered gate term with a DEPTH-stage delayed
// reference path:
//     node_out[i] = dl[i] & ~qg[i]
//
// The monitor counts "hit" cycles over windows of 2^WIN_W enabled cycles.
// A hit is a cycle where mon_en=1 and any channel of node_out is high.
// It reports the count of the last completed window, saturating at
// 2^CNT_W-1. It flags the window as rare when that count is below THRESH.
//
// Build option: define NT_NODE_MON_EN to include the monitor. Without it,
// hit_cnt, rare_flag and win_done are tied to 0, mon_en and mon_clr are
// ignored, and the node_out datapath is unchanged.
//
// Ports:
//   I1470_clk  in   1      clock, rising edge
//   I1477_rst  in   1      synchronous active-low reset
//   a_in       in   W      gate term, used combinationally
//   b_in       in   W      enable term, registered
//   c_in       in   W      select term, registered
//   d_in       in   W      reference term, registered then delayed
//   mon_en     in   1      monitor counts only when high
//   mon_clr    in   1      synchronous monitor restart
//   node_out   out  W      combined node value per channel
//   hit_cnt    out  CNT_W  hits in the last completed window
//   rare_flag  out  1      last completed window had hits < THRESH
//   win_done   out  1      one-cycle pulse when a window closes
module nt_node_monitor #(
  parameter int W      = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 10,
  parameter int THRESH = 4
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic [W-1:0]     c_in,
  input  logic [W-1:0]     d_in,
  input  logic             mon_en,
  input  logic             mon_clr,
  output logic [W-1:0]     node_out,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             rare_flag,
  output logic             win_done
);

  logic [W-1:0]            r_rb;
  logic [W-1:0]            r_rc;
  logic [W-1:0]            r_rd;
  logic [W-1:0]            r_qg;
  logic [DEPTH-1:0][W-1:0] r_dl;
  logic [W-1:0]            w_g;

  // a_in arrives one cycle after the b/c it qualifies.
  assign w_g = r_rb & ~(r_rc & a_in);

  always_ff @(posedge I1470_clk) begin
    if (!I1477_rst) begin
      r_rb <= '0;
      r_rc <= '0;
      r_rd <= '0;
      r_qg <= '0;
      r_dl <= '0;
    end else begin
      r_rb  <= b_in;
      r_rc  <= c_in;
      r_rd  <= d_in;
      r_qg  <= w_g;
      r_dl[0] <= r_rd;
      for (int s = 1; s < DEPTH; s++) begin
        r_dl[s] <= r_dl[s-1];
      end
    end
  end

  assign node_out = r_dl[DEPTH-1] & ~r_qg;

`ifdef NT_NODE_MON_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] WC_MAX  = {WIN_W{1'b1}};

  logic [CNT_W-1:0] r_cur;
  logic [WIN_W-1:0] r_wc;
  logic [CNT_W-1:0] r_hit_cnt;
  logic             r_rare;
  logic             r_done;
  logic             w_hit;
  logic [CNT_W-1:0] w_cur_next;

  assign w_hit = mon_en & (|node_out);

  // Saturating increment; also provides the closing value, so a hit on
  // the last window cycle is credited to the window that is closing.
  assign w_cur_next = (r_cur == CNT_MAX) ? r_cur : r_cur + CNT_W'(w_hit);

  always_ff @(posedge I1470_clk) begin
    if (!I1477_rst) begin
      r_cur     <= '0;
      r_wc      <= '0;
      r_hit_cnt <= '0;
      r_rare    <= 1'b0;
      r_done    <= 1'b0;
    end else if (mon_clr) begin
      // Restart the window; the last reported result is kept.
      r_cur  <= '0;
      r_wc   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (mon_en) begin
        if (r_wc == WC_MAX) begin
          r_hit_cnt <= w_cur_next;
          r_rare    <= (32'(w_cur_next) < 32'(THRESH));
          r_done    <= 1'b1;
          r_cur     <= '0;
          r_wc      <= '0;
        end else begin
          r_wc  <= r_wc + 1'b1;
          r_cur <= w_cur_next;
        end
      end
    end
  end

  assign hit_cnt   = r_hit_cnt;
  assign rare_flag = r_rare;
  assign win_done  = r_done;
`else
  logic w_unused;
  assign w_unused  = mon_en ^ mon_clr;
  assign hit_cnt   = '0;
  assign rare_flag = 1'b0;
  assign win_done  = 1'b0;
`endif

endmodule
